sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Two-requester round-robin arbiter in front of the SDRAM controller, running in the 100 MHz SDRAM domain.
- Converts level requests from requesters m0 and m1 into the controller's sdram_rd_req/sdram_wr_req plus byte counts.
- Holds each request until the matching controller ack is seen, then reports completion to the requester.
- Requester 0 is the CPU port; requester 1 is the display/DMA port.

Parameters:
- BYTES_W, 9, width of byte-count fields; matches the controller's sdwr_bytes/sdrd_bytes.
- TIMEOUT_CYCLES, 4096, watchdog limit in clocks; used only with the optional feature.

Ports:
- clk_100m  in  1  100 MHz clock
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  level request; held until m0_done
- m0_rw_n  in  1  0 = read, 1 = write
- m0_bytes  in  BYTES_W  transfer byte count
- m0_grant  out  1  m0 owns the controller
- m0_done  out  1  one-cycle completion pulse
- m1_req, m1_rw_n, m1_bytes, m1_grant, m1_done: same as m0
- sdram_init_done  in  1  controller initialisation complete
- sdram_rd_ack  in  1  controller read-data phase, multi-cycle level
- sdram_wr_ack  in  1  controller write-recovery phase, multi-cycle level
- sdram_rd_req  out  1  read request to controller
- sdram_wr_req  out  1  write request to controller
- sdrd_bytes  out  BYTES_W  latched read byte count
- sdwr_bytes  out  BYTES_W  latched write byte count
- owner  out  1  current/last granted requester; selects the data mux
- arb_timeout  out  1  one-cycle watchdog pulse; constant 0 unless the feature is compiled in

Behaviour:
Reset (rst=1 at a clk_100m edge):
- State S_IDLE.
- All outputs 0, including owner=0.
- last_owner=1, so m0 wins the first tie.
- Reset is asserted together with the controller reset; a transfer in flight is abandoned with no done pulse.

FSM:
- S_IDLE
  - Grants only when sdram_init_done=1.
  - If exactly one req is high, that requester wins.
  - If both are high, the requester != last_owner wins.
  - On a win: latch rw_n and bytes; set owner; bytes go to sdrd_bytes or sdwr_bytes (the other is held at 0); go to S_REQ.
  - Grant latency: req sampled high at edge N gives grant plus sdram_*_req at edge N+1.
- S_REQ
  - x_grant=1; sdram_rd_req=~rw_n, sdram_wr_req=rw_n.
  - Waits for the matching ack (rd_ack for reads, wr_ack for writes); the non-matching ack is ignored.
  - On the matching ack: drop sdram_*_req in the same edge and go to S_ACK.
  - Controller refresh ahead of our request only delays the ack; req stays asserted.
- S_ACK
  - Grant held, sdram_*_req=0.
  - Waits for the matching ack to fall, then goes to S_DONE.
- S_DONE
  - x_done=1 for exactly one cycle; grant stays 1 in this cycle.
  - last_owner<=owner; go to S_IDLE.
  - Grant drops the next cycle.

Handshake rules:
- Requesters deassert req on the edge after sampling done.
- A req still high in S_IDLE after that is treated as a new request.
- Changing rw_n/bytes while granted has no effect; values are latched.
- req dropped before done is ignored; the transfer completes and done still pulses.

Throughput and ordering:
- Minimum gap between consecutive grants is 2 cycles (S_DONE, S_IDLE).
- Strict alternation under continuous contention; no starvation.
- Byte counts are passed unmodified; BYTES_W bits, no arithmetic.
- sdram_init_done falling while not idle: the current transfer completes normally, and new grants stall in S_IDLE.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- With it:
  - A 13-bit counter clears on entry to S_REQ and increments in S_REQ/S_ACK.
  - On reaching TIMEOUT_CYCLES-1: drop sdram_*_req, pulse arb_timeout for 1 cycle, go to S_DONE (done still pulses, fairness still updates).
- Without it: no counter logic; arb_timeout tied 0; S_REQ/S_ACK wait indefinitely.

Test Plan:
- Hold sdram_init_done=0 for 100 cycles with m0_req=1 -> no grant and no sdram_rd_req; raise init_done -> m0_grant and sdram_rd_req high 1 cycle later.
- m0 read, bytes=9'd16; model rd_ack high 3 cycles starting 5 cycles after the req edge -> sdram_rd_req drops with the rd_ack rise, sdrd_bytes=16, m0_done pulses once 1 cycle after rd_ack falls.
- m0 and m1 both requesting writes continuously for 4 transfers -> grant order m0,m1,m0,m1; sdram_wr_req never asserted during S_ACK/S_DONE.
- During an m1 read, pulse wr_ack for 2 cycles -> ignored; completion only after the rd_ack fall.
- rst asserted mid-S_ACK -> next cycle all outputs 0, then m0 preferred on the next tie.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, never ack -> arb_timeout and m0_done pulse at cycle 64 after the grant, return to idle.

Source files
------------

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Two-requester round-robin arbiter in front of the SDRAM controller, in the
// 100 MHz SDRAM clock domain. Requester 0 is the CPU port, requester 1 is the
// display/DMA port. A level request is turned into sdram_rd_req/sdram_wr_req
// plus a latched byte count. The request is held until the matching controller
// ack rises. The arbiter then waits for that ack to fall and pulses done to the
// owning requester for one cycle.
//
// Ports:
//   clk_100m         100 MHz clock
//   rst              synchronous active-high reset
//   m0_req/m1_req    level requests, held until the matching done
//   m0_rw_n/m1_rw_n  0 = read, 1 = write (latched at grant)
//   m0_bytes/m1_bytes transfer byte counts (latched at grant)
//   m0_grant/m1_grant requester owns the controller
//   m0_done/m1_done  one-cycle completion pulse
//   sdram_init_done  controller initialisation complete (gates new grants)
//   sdram_rd_ack     controller read-data phase (multi-cycle level)
//   sdram_wr_ack     controller write-recovery phase (multi-cycle level)
//   sdram_rd_req     read request to the controller
//   sdram_wr_req     write request to the controller
//   sdrd_bytes       latched read byte count (0 for a write transfer)
//   sdwr_bytes       latched write byte count (0 for a read transfer)
//   owner            current/last granted requester; selects the data mux
//   arb_timeout      one-cycle watchdog pulse
//
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to add a watchdog.
// The watchdog forces a transfer to completion after TIMEOUT_CYCLES clocks
// in S_REQ/S_ACK. Without the macro, arb_timeout is tied low and the arbiter
// waits for the acks indefinitely.
// -----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int BYTES_W        = 9,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk_100m,
    input  logic               rst,
    input  logic               m0_req,
    input  logic               m0_rw_n,
    input  logic [BYTES_W-1:0] m0_bytes,
    output logic               m0_grant,
    output logic               m0_done,
    input  logic               m1_req,
    input  logic               m1_rw_n,
    input  logic [BYTES_W-1:0] m1_bytes,
    output logic               m1_grant,
    output logic               m1_done,
    input  logic               sdram_init_done,
    input  logic               sdram_rd_ack,
    input  logic               sdram_wr_ack,
    output logic               sdram_rd_req,
    output logic               sdram_wr_req,
    output logic [BYTES_W-1:0] sdrd_bytes,
    output logic [BYTES_W-1:0] sdwr_bytes,
    output logic               owner,
    output logic               arb_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic               owner_reg, owner_next;
    logic               last_owner_reg, last_owner_next;
    logic               rw_n_reg, rw_n_next;
    logic [BYTES_W-1:0] rd_bytes_reg, rd_bytes_next;
    logic [BYTES_W-1:0] wr_bytes_reg, wr_bytes_next;

    // Requester inputs gathered into vectors so that arbitration indexes by id.
    logic [1:0]         req_vec;
    logic [1:0]         rw_n_vec;
    logic [BYTES_W-1:0] bytes_vec [2];
    logic [1:0]         grant_vec;
    logic [1:0]         done_vec;

    logic               win_valid;
    logic               win_idx;
    logic               ack_match;
    logic               busy;
    logic               done_st;

    assign req_vec      = {m1_req, m0_req};
    assign rw_n_vec     = {m1_rw_n, m0_rw_n};
    assign bytes_vec[0] = m0_bytes;
    assign bytes_vec[1] = m1_bytes;

    // Only the ack that matches the latched direction matters. The other ack
    // belongs to the controller's own activity and is ignored.
    assign ack_match = rw_n_reg ? sdram_wr_ack : sdram_rd_ack;

    // Round-robin pick: a lone requester always wins. On a tie, the requester
    // that did not own the last completed transfer wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 1'b0;
        if (req_vec == 2'b11) begin
            win_valid = 1'b1;
            win_idx   = ~last_owner_reg;
        end else if (req_vec[0]) begin
            win_valid = 1'b1;
            win_idx   = 1'b0;
        end else if (req_vec[1]) begin
            win_valid = 1'b1;
            win_idx   = 1'b1;
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [12:0] TIMEOUT_LAST = 13'(TIMEOUT_CYCLES - 1);

    logic [12:0] cnt_reg, cnt_next;
    logic        timeout_reg;
    logic        timeout_hit;

    assign timeout_hit = ((state_reg == S_REQ) || (state_reg == S_ACK))
                         && (cnt_reg == TIMEOUT_LAST);

    // Held at zero while idle, so the count is 0 on the first S_REQ cycle.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == S_IDLE) begin
            cnt_next = '0;
        end else if ((state_reg == S_REQ) || (state_reg == S_ACK)) begin
            cnt_next = cnt_reg + 13'd1;
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_hit;
        end
    end

    // Registered so that the pulse lines up with the forced S_DONE cycle.
    assign arb_timeout = timeout_reg;
`else
    assign arb_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            rw_n_reg       <= 1'b0;
            rd_bytes_reg   <= '0;
            wr_bytes_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            rw_n_reg       <= rw_n_next;
            rd_bytes_reg   <= rd_bytes_next;
            wr_bytes_reg   <= wr_bytes_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        rw_n_next       = rw_n_reg;
        rd_bytes_next   = rd_bytes_reg;
        wr_bytes_next   = wr_bytes_reg;
        case (state_reg)
            S_IDLE: begin
                if (sdram_init_done && win_valid) begin
                    state_next = S_REQ;
                    owner_next = win_idx;
                    rw_n_next  = rw_n_vec[win_idx];
                    // Only the active direction carries a count.
                    if (rw_n_vec[win_idx]) begin
                        wr_bytes_next = bytes_vec[win_idx];
                        rd_bytes_next = '0;
                    end else begin
                        rd_bytes_next = bytes_vec[win_idx];
                        wr_bytes_next = '0;
                    end
                end
            end
            S_REQ: begin
                if (ack_match) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (!ack_match) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                last_owner_next = owner_reg;
                state_next      = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
`ifdef SDRAM_ARB_TIMEOUT_EN
        if (timeout_hit) begin
            state_next = S_DONE;
        end
`endif
    end

    // Output decode
    always_comb begin
        busy         = 1'b0;
        done_st      = 1'b0;
        sdram_rd_req = 1'b0;
        sdram_wr_req = 1'b0;
        case (state_reg)
            S_REQ: begin
                busy         = 1'b1;
                sdram_rd_req = ~rw_n_reg;
                sdram_wr_req = rw_n_reg;
            end
            S_ACK: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy    = 1'b1;
                done_st = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Per-requester grant/done decode
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign grant_vec[gi] = busy    && (owner_reg == 1'(gi));
            assign done_vec[gi]  = done_st && (owner_reg == 1'(gi));
        end
    endgenerate

    assign m0_grant   = grant_vec[0];
    assign m1_grant   = grant_vec[1];
    assign m0_done    = done_vec[0];
    assign m1_done    = done_vec[1];
    assign owner      = owner_reg;
    assign sdrd_bytes = rd_bytes_reg;
    assign sdwr_bytes = wr_bytes_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Self-checking bench for sdram_arbiter. A table of single-transfer vectors
// covers lone requesters and ties in both directions. Hand-written sequences
// cover these cases:
//   - init_done gating
//   - ack timing
//   - the non-matching ack
//   - reset in mid-transfer
//   - continuous contention
//   - the optional watchdog
// Expected completions go into a queue when a request is driven. A monitor
// pops and compares them when a done pulse appears.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int BW = 9;

    logic          clk_100m = 1'b0;
    logic          rst;
    logic          m0_req, m0_rw_n, m1_req, m1_rw_n;
    logic [BW-1:0] m0_bytes, m1_bytes;
    logic          m0_grant, m0_done, m1_grant, m1_done;
    logic          sdram_init_done, sdram_rd_ack, sdram_wr_ack;
    logic          sdram_rd_req, sdram_wr_req;
    logic [BW-1:0] sdrd_bytes, sdwr_bytes;
    logic          owner, arb_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk_100m = ~clk_100m;

    sdram_arbiter #(.BYTES_W(BW), .TIMEOUT_CYCLES(64)) dut (
        .clk_100m        (clk_100m),
        .rst             (rst),
        .m0_req          (m0_req),
        .m0_rw_n         (m0_rw_n),
        .m0_bytes        (m0_bytes),
        .m0_grant        (m0_grant),
        .m0_done         (m0_done),
        .m1_req          (m1_req),
        .m1_rw_n         (m1_rw_n),
        .m1_bytes        (m1_bytes),
        .m1_grant        (m1_grant),
        .m1_done         (m1_done),
        .sdram_init_done (sdram_init_done),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_req    (sdram_wr_req),
        .sdrd_bytes      (sdrd_bytes),
        .sdwr_bytes      (sdwr_bytes),
        .owner           (owner),
        .arb_timeout     (arb_timeout)
    );

    typedef struct {
        logic          who;
        logic          wr;
        logic [BW-1:0] bytes;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic          r0;
        logic          rw0;
        logic [BW-1:0] b0;
        logic          r1;
        logic          rw1;
        logic [BW-1:0] b1;
        logic          who;
        logic          exp_rd;
        logic          exp_wr;
        logic [BW-1:0] exp_bytes;
        int            delay;
        int            len;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic push(input logic who, input logic wr, input logic [BW-1:0] b);
        exp_t e;
        e.who   = who;
        e.wr    = wr;
        e.bytes = b;
        sb_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {m0_grant, m0_done, m1_grant, m1_done, sdram_rd_req, sdram_wr_req,
                   owner, arb_timeout, sdrd_bytes, sdwr_bytes}, 32'd0);
    endtask

    // Called one cycle after the grant is visible. Keeps the request asserted
    // for 'delay' cycles. Then raises the matching ack for 'len' sampled
    // cycles, drops it, and checks the done cycle and the return to idle.
    task automatic run_ack(input logic idx, input logic wr, input int delay,
                           input int len, input logic drop);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("req_hold", wr ? sdram_wr_req : sdram_rd_req, 1);
        end
        if (wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
        for (int i = 0; i < len; i++) begin
            step();
            chk("req_drop_in_ack", {sdram_rd_req, sdram_wr_req}, 0);
            chk("grant_in_ack", idx ? m1_grant : m0_grant, 1);
            chk("no_done_in_ack", {m1_done, m0_done}, 0);
        end
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        step();
        chk("done_pulse", {m1_done, m0_done}, idx ? 2'b10 : 2'b01);
        chk("grant_in_done", idx ? m1_grant : m0_grant, 1);
        chk("no_req_in_done", {sdram_rd_req, sdram_wr_req}, 0);
        chk("no_timeout", arb_timeout, 0);
        if (drop) begin
            if (idx) m1_req = 1'b0; else m0_req = 1'b0;
        end
        step();
        chk("idle_no_grant", {m1_grant, m0_grant}, 0);
        chk("done_once", {m1_done, m0_done}, 0);
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk_100m) begin : sb_mon
        exp_t e;
        if (!rst && (m0_done || m1_done)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got m0_done=%0b m1_done=%0b, expected none",
                         m0_done, m1_done);
            end else begin
                e = sb_q.pop_front();
                chk("sb_who", {m1_done, m0_done}, e.who ? 2'b10 : 2'b01);
                chk("sb_owner", owner, e.who);
                chk("sb_bytes", e.wr ? sdwr_bytes : sdrd_bytes, e.bytes);
                chk("sb_other_bytes", e.wr ? sdrd_bytes : sdwr_bytes, 0);
                $display("txn: m%0d %s bytes=%0d", e.who, e.wr ? "write" : "read", e.bytes);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic bad;
        int   n;

        //          r0   rw0  b0      r1   rw1  b1      who  rd   wr   bytes   d  l
        vecs[0] = '{1'b0,1'b0,9'h000, 1'b1,1'b0,9'h0AA, 1'b1,1'b1,1'b0,9'h0AA, 1, 2};
        vecs[1] = '{1'b1,1'b1,9'h1FF, 1'b0,1'b0,9'h000, 1'b0,1'b0,1'b1,9'h1FF, 0, 1};
        vecs[2] = '{1'b1,1'b0,9'h011, 1'b1,1'b1,9'h100, 1'b1,1'b0,1'b1,9'h100, 2, 3};
        vecs[3] = '{1'b1,1'b1,9'h000, 1'b1,1'b0,9'h033, 1'b0,1'b0,1'b1,9'h000, 3, 1};
        vecs[4] = '{1'b0,1'b0,9'h000, 1'b1,1'b1,9'h123, 1'b1,1'b0,1'b1,9'h123, 1, 1};
        vecs[5] = '{1'b0,1'b0,9'h000, 1'b1,1'b0,9'h0F0, 1'b1,1'b1,1'b0,9'h0F0, 0, 2};
        vecs[6] = '{1'b1,1'b0,9'h001, 1'b1,1'b0,9'h002, 1'b0,1'b1,1'b0,9'h001, 2, 2};

        rst = 1'b1;
        m0_req = 0; m0_rw_n = 0; m0_bytes = '0;
        m1_req = 0; m1_rw_n = 0; m1_bytes = '0;
        sdram_init_done = 0; sdram_rd_ack = 0; sdram_wr_ack = 0;
        repeat (3) step();
        chk_all_zero("reset_outputs");
        rst = 1'b0;

        // init_done low: no grant for 100 cycles, then grant one cycle after it rises
        m0_req = 1'b1; m0_rw_n = 1'b0; m0_bytes = 9'd5;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            bad = bad | m0_grant | m1_grant | sdram_rd_req | sdram_wr_req;
        end
        chk("init_hold_no_grant", bad, 0);
        push(1'b0, 1'b0, 9'd5);
        sdram_init_done = 1'b1;
        step();
        chk("init_grant", m0_grant, 1);
        chk("init_rd_req", sdram_rd_req, 1);
        chk("init_wr_req", sdram_wr_req, 0);
        run_ack(1'b0, 1'b0, 2, 2, 1'b1);

        // m0 read of 16 bytes, rd_ack high for 3 cycles after a 5-cycle wait
        push(1'b0, 1'b0, 9'd16);
        m0_req = 1'b1; m0_rw_n = 1'b0; m0_bytes = 9'd16;
        step();
        chk("rd16_grant", m0_grant, 1);
        chk("rd16_bytes", sdrd_bytes, 16);
        chk("rd16_wr_bytes", sdwr_bytes, 0);
        run_ack(1'b0, 1'b0, 4, 3, 1'b1);

        // m1 read with a spurious 2-cycle wr_ack pulse
        push(1'b1, 1'b0, 9'h040);
        m1_req = 1'b1; m1_rw_n = 1'b0; m1_bytes = 9'h040;
        step();
        chk("m1rd_grant", m1_grant, 1);
        sdram_wr_ack = 1'b1;
        step();
        chk("wr_ack_ignored_0", sdram_rd_req, 1);
        step();
        chk("wr_ack_ignored_1", sdram_rd_req, 1);
        chk("wr_ack_no_done", m1_done, 0);
        sdram_wr_ack = 1'b0;
        run_ack(1'b1, 1'b0, 1, 2, 1'b1);

        // Table-driven transfers. Direction and count change after grant must be ignored.
        foreach (vecs[k]) begin
            m0_req = vecs[k].r0; m0_rw_n = vecs[k].rw0; m0_bytes = vecs[k].b0;
            m1_req = vecs[k].r1; m1_rw_n = vecs[k].rw1; m1_bytes = vecs[k].b1;
            push(vecs[k].who, vecs[k].exp_wr, vecs[k].exp_bytes);
            step();
            chk("vec_m0_grant", m0_grant, !vecs[k].who);
            chk("vec_m1_grant", m1_grant, vecs[k].who);
            chk("vec_owner", owner, vecs[k].who);
            chk("vec_rd_req", sdram_rd_req, vecs[k].exp_rd);
            chk("vec_wr_req", sdram_wr_req, vecs[k].exp_wr);
            chk("vec_bytes", vecs[k].exp_wr ? sdwr_bytes : sdrd_bytes, vecs[k].exp_bytes);
            m0_rw_n = ~m0_rw_n; m1_rw_n = ~m1_rw_n;
            m0_bytes = BW'($urandom); m1_bytes = BW'($urandom);
            run_ack(vecs[k].who, vecs[k].exp_wr, vecs[k].delay, vecs[k].len, 1'b1);
            m0_req = 1'b0; m1_req = 1'b0;
        end

        // Reset in the middle of S_ACK abandons the transfer with no done pulse
        m1_req = 1'b1; m1_rw_n = 1'b1; m1_bytes = 9'h077;
        step();
        chk("rst_pre_grant", m1_grant, 1);
        sdram_wr_ack = 1'b1;
        step();
        chk("rst_pre_ack_state", {m1_grant, sdram_wr_req}, 2'b10);
        rst = 1'b1;
        step();
        chk_all_zero("rst_mid_ack");
        rst = 1'b0; sdram_wr_ack = 1'b0; m1_req = 1'b0;

        // Continuous contention on writes: m0 first after reset, then strict alternation
        m0_req = 1'b1; m0_rw_n = 1'b1; m0_bytes = 9'h020;
        m1_req = 1'b1; m1_rw_n = 1'b1; m1_bytes = 9'h1FF;
        for (int t = 0; t < 4; t++) begin
            push(t[0], 1'b1, t[0] ? 9'h1FF : 9'h020);
            step();
            chk("cont_owner", {m1_grant, m0_grant}, t[0] ? 2'b10 : 2'b01);
            chk("cont_wr_req", sdram_wr_req, 1);
            run_ack(t[0], 1'b1, 1, 1, 1'b0);
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // init_done falling mid-transfer: transfer completes, new grants stall
        push(1'b0, 1'b0, 9'h00C);
        m0_req = 1'b1; m0_rw_n = 1'b0; m0_bytes = 9'h00C;
        step();
        chk("initfall_grant", m0_grant, 1);
        sdram_init_done = 1'b0;
        run_ack(1'b0, 1'b0, 1, 1, 1'b1);
        m0_req = 1'b1; m0_bytes = 9'h00D;
        bad = 1'b0;
        repeat (5) begin
            step();
            bad = bad | m0_grant | sdram_rd_req;
        end
        chk("initfall_stall", bad, 0);
        push(1'b0, 1'b0, 9'h00D);
        sdram_init_done = 1'b1;
        step();
        chk("initfall_regrant", m0_grant, 1);
        run_ack(1'b0, 1'b0, 0, 1, 1'b1);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Never ack: watchdog fires 64 cycles after the grant
        push(1'b0, 1'b0, 9'h008);
        m0_req = 1'b1; m0_rw_n = 1'b0; m0_bytes = 9'h008;
        step();
        chk("to_grant", m0_grant, 1);
        n = 0;
        while (!m0_done && n < 200) begin
            step();
            n++;
        end
        chk("to_latency", n, 64);
        chk("to_pulse", arb_timeout, 1);
        m0_req = 1'b0;
        step();
        chk("to_pulse_once", arb_timeout, 0);
        chk("to_idle", m0_grant, 0);
`else
        n = 0;
`endif

        step();
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
